memory_cycle: RTL and testbench

//  Memory stage: consumes the EX/MEM bundle (RegWriteM, MemWriteM, ResultSrcM, RD_M, ALU_ResultM, WriteDataM, PCPlus4M)
//  and performs loads/stores over a req/ack data-memory port with variable latency.

---
 rtl/memory_cycle.sv | 212 +++++++++++++++++++++
 tb/tb_memory_cycle.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_cycle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | memory_cycle : pipeline memory stage with req/ack data port and MEM/WB reg |
// | Revision     : 1.0                                                         |
// +--------------------------------------------------------------------------+
module memory_cycle #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  Funct3M,
  input  logic [4:0]  RD_M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic        MisalignW,
  output logic        BusErrW
);

  localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t r_state, w_next;

  logic               r_regWrite, r_memWrite;
  logic [1:0]         r_resultSrc;
  logic [2:0]         r_funct3;
  logic [4:0]         r_rd;
  logic [31:0]        r_addr, r_wdata, r_pcPlus4;
  logic [c_CNT_W-1:0] r_cnt;

  logic        w_sRegWrite, w_sMemWrite;
  logic [1:0]  w_sResultSrc;
  logic [2:0]  w_sFunct3;
  logic [4:0]  w_sRd;
  logic [31:0] w_sAddr, w_sWdata, w_sPcPlus4;

  logic        w_isByte, w_isHalf, w_isLoad, w_access, w_misaligned, w_timeout;
  logic [1:0]  w_off;
  logic [31:0] w_shifted, w_loadData;
  logic        w_capture, w_abort, w_misPulse, w_latch;

  // Once waiting, the access is driven from the bundle latched on entry.
  always_comb begin
    if (r_state == S_WAIT) begin
      w_sRegWrite  = r_regWrite;
      w_sMemWrite  = r_memWrite;
      w_sResultSrc = r_resultSrc;
      w_sFunct3    = r_funct3;
      w_sRd        = r_rd;
      w_sAddr      = r_addr;
      w_sWdata     = r_wdata;
      w_sPcPlus4   = r_pcPlus4;
    end else begin
      w_sRegWrite  = RegWriteM;
      w_sMemWrite  = MemWriteM;
      w_sResultSrc = ResultSrcM;
      w_sFunct3    = Funct3M;
      w_sRd        = RD_M;
      w_sAddr      = ALU_ResultM;
      w_sWdata     = WriteDataM;
      w_sPcPlus4   = PCPlus4M;
    end
  end

  assign w_off        = w_sAddr[1:0];
  assign w_isByte     = (w_sFunct3[1:0] == 2'b00);
  assign w_isHalf     = (w_sFunct3[1:0] == 2'b01);
  assign w_isLoad     = (w_sResultSrc == 2'b01);
  assign w_access     = w_isLoad | w_sMemWrite;
  assign w_misaligned = (w_isHalf & w_off[0]) | (!w_isByte & !w_isHalf & (w_off != 2'b00));
  assign w_timeout    = (TIMEOUT != 0) && (r_cnt == c_LAST);

  assign dmem_addr  = {w_sAddr[31:2], 2'b00};
  assign dmem_we    = w_sMemWrite;
  assign dmem_be    = w_isByte ? (4'b0001 << w_off) :
                      w_isHalf ? (4'b0011 << {w_off[1], 1'b0}) : 4'b1111;
  assign dmem_wdata = w_isByte ? {4{w_sWdata[7:0]}} :
                      w_isHalf ? {2{w_sWdata[15:0]}} : w_sWdata;

  // A single byte-granular shift serves both byte and half lanes.
  assign w_shifted  = dmem_rdata >> {w_off, 3'b000};
  assign w_loadData = w_isByte ? (w_sFunct3[2] ? {24'd0, w_shifted[7:0]}
                                               : {{24{w_shifted[7]}}, w_shifted[7:0]}) :
                      w_isHalf ? (w_sFunct3[2] ? {16'd0, w_shifted[15:0]}
                                               : {{16{w_shifted[15]}}, w_shifted[15:0]}) :
                      dmem_rdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    dmem_req   = 1'b0;
    StallM     = 1'b0;
    w_capture  = 1'b0;
    w_abort    = 1'b0;
    w_misPulse = 1'b0;
    w_latch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access && !w_misaligned) begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            w_capture = 1'b1;
          end else begin
            w_next  = S_WAIT;
            StallM  = 1'b1;
            w_latch = 1'b1;
          end
        end else if (w_access) begin
          w_misPulse = 1'b1;
        end else begin
          w_capture = 1'b1;
        end
      end
      S_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          w_capture = 1'b1;
          w_next    = S_IDLE;
        end else if (w_timeout) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else begin
          StallM = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (rst) begin
      dmem_req = 1'b0;
      StallM   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_regWrite  <= 1'b0;
      r_memWrite  <= 1'b0;
      r_resultSrc <= 2'b00;
      r_funct3    <= 3'b000;
      r_rd        <= 5'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_pcPlus4   <= 32'd0;
    end else if (w_latch) begin
      r_regWrite  <= RegWriteM;
      r_memWrite  <= MemWriteM;
      r_resultSrc <= ResultSrcM;
      r_funct3    <= Funct3M;
      r_rd        <= RD_M;
      r_addr      <= ALU_ResultM;
      r_wdata     <= WriteDataM;
      r_pcPlus4   <= PCPlus4M;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || r_state != S_WAIT || w_next != S_WAIT) r_cnt <= '0;
    else                                              r_cnt <= r_cnt + c_CNT_W'(1);
  end

  // Anything that does not retire this cycle leaves a zeroed bubble in W.
  always_ff @(posedge clk) begin
    if (rst || !w_capture) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 2'b00;
      RD_W        <= 5'd0;
      ALU_ResultW <= 32'd0;
      ReadDataW   <= 32'd0;
      PCPlus4W    <= 32'd0;
      MisalignW   <= !rst && w_misPulse;
      BusErrW     <= !rst && w_abort;
    end else begin
      RegWriteW   <= w_sRegWrite;
      ResultSrcW  <= w_sResultSrc;
      RD_W        <= w_sRd;
      ALU_ResultW <= w_sAddr;
      ReadDataW   <= w_loadData;
      PCPlus4W    <= w_sPcPlus4;
      MisalignW   <= 1'b0;
      BusErrW     <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_cycle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_memory_cycle : scoreboard bench for memory_cycle with random accesses   |
// | Revision        : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_memory_cycle;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RD_M;
  logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        StallM, RegWriteW, MisalignW, BusErrW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          zero;
    bit          bubble;
    bit          mis;
    bit          berr;
    bit          isLoad;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  memory_cycle #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .Funct3M(Funct3M), .RD_M(RD_M), .ALU_ResultM(ALU_ResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .MisalignW(MisalignW), .BusErrW(BusErrW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: access size in bytes, derived from the funct3 rules.
  function automatic int sizeOf(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [31:0] extLoad(input logic [2:0] f, input int off, input logic [31:0] rd);
    int     sz = sizeOf(f);
    longint v  = rd >> (8 * off);
    if (sz < 4) begin
      v = v % (longint'(1) << (8 * sz));
      if (f < 3'd4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    end
    return 32'(v);
  endfunction

  function automatic logic [3:0] beOf(input logic [2:0] f, input int off);
    int sz = sizeOf(f);
    if (sz == 1) return 4'(1 << off);
    if (sz == 2) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] wdOf(input logic [2:0] f, input logic [31:0] wd);
    int sz = sizeOf(f);
    if (sz == 1) return (wd % 256) * 32'h0101_0101;
    if (sz == 2) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  // lat: request cycle index (0 = same cycle) on which ack is given; -1 = never.
  task automatic run_instr(input logic rw, input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                           input logic [31:0] pc4, input logic [31:0] rdat, input int lat);
    exp_t e, c;
    int   off, sz;
    bit   isLd, acc;
    @(negedge clk);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; Funct3M = f3; RD_M = rd;
    ALU_ResultM = alu; WriteDataM = wd; PCPlus4M = pc4; dmem_rdata = rdat; dmem_ack = 1'b0;
    off  = int'(alu[1:0]);
    sz   = sizeOf(f3);
    isLd = (rs == 2'b01);
    acc  = isLd || mw;
    e = '{zero: 0, bubble: 0, mis: 0, berr: 0, isLoad: isLd, rw: rw, rd: rd, rs: rs,
          alu: alu, pc4: pc4, rdata: extLoad(f3, off, rdat)};
    if (!acc || (off % sz) != 0) begin
      #1;
      chk("req_noaccess", {31'd0, dmem_req}, 32'd0);
      chk("stall_noaccess", {31'd0, StallM}, 32'd0);
      if (acc) begin
        e.bubble = 1;
        e.mis    = 1;
      end
      sb.push_back(e);
    end else begin
      for (int k = 0; k <= TO; k++) begin
        if (k > 0) @(negedge clk);
        dmem_ack = (k == lat);
        #1;
        chk("req", {31'd0, dmem_req}, 32'd1);
        chk("addr", dmem_addr, {alu[31:2], 2'b00});
        chk("we", {31'd0, dmem_we}, {31'd0, mw});
        chk("be", {28'd0, dmem_be}, {28'd0, beOf(f3, off)});
        if (mw) chk("wdata", dmem_wdata, wdOf(f3, wd));
        chk("stall", {31'd0, StallM}, {31'd0, (k != lat) && (k != TO)});
        c = e;
        if (k == lat) begin
          sb.push_back(c);
          break;
        end
        c.bubble = 1;
        if (k == TO) c.berr = 1;
        sb.push_back(c);
      end
    end
  endtask

  // Monitor: the W register advances every cycle, so one expectation per edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("MisalignW", {31'd0, MisalignW}, {31'd0, e.mis});
      chk("BusErrW", {31'd0, BusErrW}, {31'd0, e.berr});
      chk("RegWriteW", {31'd0, RegWriteW}, {31'd0, (e.bubble || e.zero) ? 1'b0 : e.rw});
      chk("RD_W", {27'd0, RD_W}, {27'd0, (e.bubble || e.zero) ? 5'd0 : e.rd});
      if (e.zero) begin
        chk("rst_ResultSrcW", {30'd0, ResultSrcW}, 32'd0);
        chk("rst_ALU_ResultW", ALU_ResultW, 32'd0);
        chk("rst_ReadDataW", ReadDataW, 32'd0);
        chk("rst_PCPlus4W", PCPlus4W, 32'd0);
      end else if (!e.bubble) begin
        chk("ResultSrcW", {30'd0, ResultSrcW}, {30'd0, e.rs});
        chk("ALU_ResultW", ALU_ResultW, e.alu);
        chk("PCPlus4W", PCPlus4W, e.pc4);
        if (e.isLoad) chk("ReadDataW", ReadDataW, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    z = '{zero: 1, bubble: 0, mis: 0, berr: 0, isLoad: 0, rw: 0, rd: 0, rs: 0,
          alu: 0, pc4: 0, rdata: 0};
    rst = 1'b1; RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b00; Funct3M = 3'd0;
    RD_M = 5'd9; ALU_ResultM = 32'h55; WriteDataM = 32'd0; PCPlus4M = 32'h44;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    sb.push_back(z);
    @(negedge clk);
    sb.push_back(z);
    @(negedge clk);
    #1;
    chk("reset_req", {31'd0, dmem_req}, 32'd0);
    chk("reset_stall", {31'd0, StallM}, 32'd0);
    rst = 1'b0;

    // Directed cases
    run_instr(1'b1, 1'b0, 2'b00, 3'd0, 5'd5, 32'd7, 32'd0, 32'h1004, 32'd0, 0);
    run_instr(1'b0, 1'b1, 2'b00, 3'd2, 5'd0, 32'h100, 32'hDEADBEEF, 32'h1008, 32'd0, 0);
    run_instr(1'b1, 1'b0, 2'b01, 3'd0, 5'd3, 32'h103, 32'd0, 32'h100C, 32'h80112233, 3);
    run_instr(1'b1, 1'b0, 2'b01, 3'd4, 5'd3, 32'h103, 32'd0, 32'h1010, 32'h80112233, 3);
    run_instr(1'b0, 1'b1, 2'b00, 3'd1, 5'd0, 32'h102, 32'h0000ABCD, 32'h1014, 32'd0, 0);
    run_instr(1'b1, 1'b0, 2'b01, 3'd1, 5'd4, 32'h101, 32'd0, 32'h1018, 32'd0, 0);
    run_instr(1'b1, 1'b0, 2'b01, 3'd2, 5'd6, 32'h200, 32'd0, 32'h101C, 32'h12345678, -1);
    run_instr(1'b1, 1'b0, 2'b01, 3'd5, 5'd7, 32'h302, 32'd0, 32'h1020, 32'hF00D8001, 1);

    // Reset while waiting: load, no ack, rst raised in the second WAIT cycle.
    @(negedge clk);
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; Funct3M = 3'd2; RD_M = 5'd8;
    ALU_ResultM = 32'h400; PCPlus4M = 32'h1024; dmem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 2) begin
        rst = 1'b1;
        RegWriteM = 1'b0; ResultSrcM = 2'b00; RD_M = 5'd0; ALU_ResultM = 32'd0; PCPlus4M = 32'd0;
        sb.push_back(z);
      end else begin
        #1;
        chk("rstwait_stall", {31'd0, StallM}, 32'd1);
        sb.push_back('{zero: 0, bubble: 1, mis: 0, berr: 0, isLoad: 1, rw: 1, rd: 8, rs: 1,
                       alu: 32'h400, pc4: 32'h1024, rdata: 0});
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req", {31'd0, dmem_req}, 32'd0);
    chk("post_rst_stall", {31'd0, StallM}, 32'd0);
    sb.push_back('{zero: 0, bubble: 0, mis: 0, berr: 0, isLoad: 0, rw: 0, rd: 0, rs: 0,
                   alu: 0, pc4: 0, rdata: 0});

    // Randomized mix of ALU ops, loads and stores with random latencies.
    for (int n = 0; n < 200; n++) begin
      int          kind, lat;
      logic [31:0] alu;
      logic [2:0]  f3;
      kind = $urandom_range(0, 3);
      lat  = ($urandom_range(0, 7) == 7) ? -1 : $urandom_range(0, TO);
      alu  = $urandom;
      if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
      f3 = 3'($urandom_range(0, 7));
      case (kind)
        0: run_instr(1'b1, 1'b0, 2'($urandom_range(0, 3) & 2'b10), f3, 5'($urandom), alu,
                     $urandom, $urandom, $urandom, lat);
        1: run_instr(1'b1, 1'b0, 2'b01, f3, 5'($urandom), alu, $urandom, $urandom, $urandom, lat);
        2: run_instr(1'b0, 1'b1, 2'b00, 3'($urandom_range(0, 2)), 5'($urandom), alu,
                     $urandom, $urandom, $urandom, lat);
        default: run_instr(1'b1, 1'b0, 2'b11, f3, 5'($urandom), alu, $urandom, $urandom,
                           $urandom, lat);
      endcase
    end

    @(negedge clk);
    RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00; dmem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
